// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down modulus counter.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the count enable down to one step tick every PRESCALE enabled cycles.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  if (PRESCALE == 1) begin : g_bypass
    logic unused_ok;
    assign unused_ok = clk ^ reset ^ clr;
    assign tick      = en;
  end else begin : g_div
    localparam int PS_W = clog2_min1(PRESCALE);
    localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] cnt;

    always_ff @(posedge clk) begin
      if (reset || clr) begin
        cnt <= '0;
      end else if (en) begin
        cnt <= (cnt == LAST) ? '0 : cnt + PS_W'(1);
      end
    end

    assign tick = en & (cnt == LAST);
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down counter over 0..limit with load, wrap/saturate mode and prescaled stepping.
// Optional sticky overflow flag when UPDOWN_MOD_COUNTER_OVF_STICKY_EN is defined.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             sat_mode,
`ifdef UPDOWN_MOD_COUNTER_OVF_STICKY_EN
  input  logic             ovf_clr,
  output logic             ovf_sticky,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  logic             step_tick;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] load_clamped;
  logic             wrap_ev;
  logic             sat_blk;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (load),
    .tick  (step_tick)
  );

  assign load_clamped = (load_val > limit) ? limit : load_val;

  // Upward boundary includes counts stranded above a lowered limit.
  assign tc = step_tick & ((up_dn == DIR_UP) ? (count >= limit) : (count == '0));

  always_comb begin
    next_count = count;
    wrap_ev    = 1'b0;
    sat_blk    = 1'b0;
    if (up_dn == DIR_UP) begin
      if (count < limit) begin
        next_count = count + WIDTH'(1);
      end else if (count > limit) begin
        next_count = '0;
        wrap_ev    = 1'b1;
      end else if (sat_mode == MODE_SAT) begin
        sat_blk    = 1'b1;
      end else begin
        next_count = '0;
        wrap_ev    = 1'b1;
      end
    end else begin
      if (count > limit) begin
        next_count = limit;
      end else if (count != '0) begin
        next_count = count - WIDTH'(1);
      end else if (sat_mode == MODE_SAT) begin
        sat_blk    = 1'b1;
      end else begin
        next_count = limit;
        wrap_ev    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      wrap  <= 1'b0;
    end else if (step_tick) begin
      count <= next_count;
      wrap  <= wrap_ev;
    end else begin
      wrap  <= 1'b0;
    end
  end

`ifdef UPDOWN_MOD_COUNTER_OVF_STICKY_EN
  logic ovf_set;
  assign ovf_set = !load & step_tick & (wrap_ev | sat_blk);

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_sticky <= 1'b0;
    end else if (ovf_set) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end
`else
  logic unused_sat;
  assign unused_sat = sat_blk;
`endif

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: PRESCALE=1 and PRESCALE=3 instances against a rule model.
module tb_updown_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, en, up_dn, load, sat_mode;
  logic [3:0] load_val, limit;
  logic [3:0] count1, count3;
  logic       tc1, tc3, wrap1, wrap3;
`ifdef UPDOWN_MOD_COUNTER_OVF_STICKY_EN
  logic       ovf_clr;
  logic       ovf1, ovf3;
`endif

  updown_mod_counter #(.WIDTH(4), .PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .limit(limit), .sat_mode(sat_mode),
`ifdef UPDOWN_MOD_COUNTER_OVF_STICKY_EN
    .ovf_clr(ovf_clr), .ovf_sticky(ovf1),
`endif
    .count(count1), .tc(tc1), .wrap(wrap1));

  updown_mod_counter #(.WIDTH(4), .PRESCALE(3)) dut3 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .limit(limit), .sat_mode(sat_mode),
`ifdef UPDOWN_MOD_COUNTER_OVF_STICKY_EN
    .ovf_clr(ovf_clr), .ovf_sticky(ovf3),
`endif
    .count(count3), .tc(tc3), .wrap(wrap3));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: count value, pending wrap pulse, number of enabled cycles modulo P, overflow flag.
  typedef struct {
    int cnt;
    bit wrp;
    int pre;
    bit ovf;
  } mstate_t;

  mstate_t m1 = '{0, 1'b0, 0, 1'b0};
  mstate_t m3 = '{0, 1'b0, 0, 1'b0};

  function automatic bit m_tick(mstate_t s, int p);
    return en && (s.pre == p - 1);
  endfunction

  function automatic bit m_tc(mstate_t s, int p);
    if (!m_tick(s, p)) return 1'b0;
    if (up_dn) return s.cnt >= int'(limit);
    return s.cnt == 0;
  endfunction

  function automatic mstate_t m_step(mstate_t s, int p);
    mstate_t n;
    int lim;
    bit event_hit;
    n = s;
    n.wrp = 1'b0;
    event_hit = 1'b0;
    lim = int'(limit);
    if (reset) begin
      n.cnt = 0; n.pre = 0; n.ovf = 1'b0;
      return n;
    end
`ifdef UPDOWN_MOD_COUNTER_OVF_STICKY_EN
    if (ovf_clr) n.ovf = 1'b0;
`endif
    if (load) begin
      n.cnt = (int'(load_val) > lim) ? lim : int'(load_val);
      n.pre = 0;
      return n;
    end
    if (!en) return n;
    n.pre = (s.pre + 1) % p;
    if (s.pre != p - 1) return n;
    if (up_dn) begin
      if (s.cnt < lim) n.cnt = s.cnt + 1;
      else if (s.cnt > lim || !sat_mode) begin n.cnt = 0; n.wrp = 1'b1; end
      else event_hit = 1'b1;
    end else begin
      if (s.cnt > lim) n.cnt = lim;
      else if (s.cnt > 0) n.cnt = s.cnt - 1;
      else if (!sat_mode) begin n.cnt = lim; n.wrp = 1'b1; end
      else event_hit = 1'b1;
    end
    if (n.wrp || event_hit) n.ovf = 1'b1;
    return n;
  endfunction

  always @(posedge clk) begin
    m1 <= m_step(m1, 1);
    m3 <= m_step(m3, 3);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_count1", count1, m1.cnt);
      chk("model_wrap1", wrap1, m1.wrp);
      chk("model_tc1", tc1, m_tc(m1, 1));
      chk("model_count3", count3, m3.cnt);
      chk("model_wrap3", wrap3, m3.wrp);
      chk("model_tc3", tc3, m_tc(m3, 3));
`ifdef UPDOWN_MOD_COUNTER_OVF_STICKY_EN
      chk("model_ovf1", ovf1, m1.ovf);
      chk("model_ovf3", ovf3, m3.ovf);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seq1[12];
    seq1 = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; sat_mode = 1'b0;
    load_val = 4'd0; limit = 4'd9;
`ifdef UPDOWN_MOD_COUNTER_OVF_STICKY_EN
    ovf_clr = 1'b0;
`endif
    step();
    chk_on = 1'b1;
    chk("reset_count", count1, 0);
    chk("reset_wrap", wrap1, 0);

    // Decade count up in wrap mode.
    reset = 1'b0; en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("t1_count", count1, seq1[k]);
      chk("t1_wrap", wrap1, (k == 9) ? 1 : 0);
      chk("t1_tc", tc1, (seq1[k] == 9) ? 1 : 0);
    end

    // Down through zero in wrap mode, then saturate at zero.
    load = 1'b1; load_val = 4'd0;
    step();
    chk("t2_load0", count1, 0);
    load = 1'b0; up_dn = 1'b0;
    step(); chk("t2_c9", count1, 9); chk("t2_wrap9", wrap1, 1);
    step(); chk("t2_c8", count1, 8); chk("t2_wrap8", wrap1, 0);
    step(); chk("t2_c7", count1, 7);
    load = 1'b1; load_val = 4'd1;
    step();
    load = 1'b0; sat_mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t2_sat_count", count1, 0);
      chk("t2_sat_wrap", wrap1, 0);
      chk("t2_sat_tc", tc1, 1);
    end

    // Load clamps to limit, loads while paused, pause holds.
    sat_mode = 1'b0; load = 1'b1; load_val = 4'd12;
    step(); chk("t3_clamp", count1, 9);
    en = 1'b0; load_val = 4'd5;
    step(); chk("t3_load_paused", count1, 5);
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin step(); chk("t3_hold", count1, 5); end
    en = 1'b1; up_dn = 1'b1;
    step(); chk("t3_resume", count1, 6);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin step(); chk("t3_pause", count1, 6); end

    // Prescaled stepping and the effect of a pause on it.
    reset = 1'b1;
    step();
    reset = 1'b0; limit = 4'd15; up_dn = 1'b1; en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("t4_prescale", count3, k / 3);
    end
    en = 1'b0;
    step(); chk("t4_pause_a", count3, 3);
    step(); chk("t4_pause_b", count3, 3);
    en = 1'b1;
    step(); chk("t4_delay", count3, 3);
    step(); chk("t4_step", count3, 4);

    // Limit lowered below the current count.
    en = 1'b0; limit = 4'd15; load = 1'b1; load_val = 4'd7;
    step(); chk("t5_load7", count1, 7);
    load = 1'b0; limit = 4'd4; up_dn = 1'b0; en = 1'b1;
    step(); chk("t5_down_clamp", count1, 4); chk("t5_down_nowrap", wrap1, 0);
    en = 1'b0; limit = 4'd15; load = 1'b1;
    step();
    load = 1'b0; limit = 4'd4; up_dn = 1'b1; en = 1'b1;
    step(); chk("t5_up_over", count1, 0); chk("t5_up_wrap", wrap1, 1);
    reset = 1'b1; load = 1'b1; load_val = 4'd3;
    step(); chk("t5_rst_load_count", count1, 0); chk("t5_rst_load_wrap", wrap1, 0);
    reset = 1'b0; load = 1'b0;

    // Zero limit wraps on every step.
    limit = 4'd0; en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
    step(); chk("lim0_up", count1, 0); chk("lim0_up_wrap", wrap1, 1);
    step(); chk("lim0_up_wrap2", wrap1, 1);
    up_dn = 1'b0;
    step(); chk("lim0_dn", count1, 0); chk("lim0_dn_wrap", wrap1, 1);

`ifdef UPDOWN_MOD_COUNTER_OVF_STICKY_EN
    chk("t6_ovf_set_lim0", ovf1, 1);
    ovf_clr = 1'b1; en = 1'b0;
    step(); chk("t6_clr", ovf1, 0);
    ovf_clr = 1'b0; limit = 4'd9; load = 1'b1; load_val = 4'd9;
    step(); chk("t6_load_keeps", ovf1, 0);
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    step(); chk("t6_wrap_set", ovf1, 1);
    ovf_clr = 1'b1; en = 1'b0;
    step(); chk("t6_clr2", ovf1, 0);
    ovf_clr = 1'b0; load = 1'b1;
    step();
    load = 1'b0; en = 1'b1; ovf_clr = 1'b1;
    step(); chk("t6_set_wins", ovf1, 1);
    ovf_clr = 1'b0;
`endif

    en = 1'b0;
    step();
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
